// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared types, constants and helpers for the 4x4 keypad scanner.
//   - state_t      : scanner FSM states (SCAN, DEBOUNCE, PRESSED, HELD)
//   - KEY_*        : legend values of the keypad caps (digits, A..D, *, #)
//   - COL_RESET    : column drive after reset (column 0 driven low)
//   - to_gray      : 4-bit binary to Gray conversion
//   - lowest_low_row / col_index / key_value : key position helpers
// ---------------------------------------------------------------------------
package keypad_pkg;

  // Raw encodings kept as plain constants so older code can compare against
  // them directly; the enum below reuses the same values.
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_HELD     = 2'd3;

  typedef enum logic [1:0] {
    SCAN     = ST_SCAN,
    DEBOUNCE = ST_DEBOUNCE,
    PRESSED  = ST_PRESSED,
    HELD     = ST_HELD
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Legend values of the printed keycaps.
  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  function automatic logic [3:0] to_gray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction

  // Index of the lowest-numbered row pulled low; 0 when no row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Index of the driven (zero) column of a one-cold column vector.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Scanned key value: row*4 + col.
  function automatic logic [3:0] key_value(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Printed legend of the key at position row*4+col, for downstream
  // consumers that want the cap value rather than the matrix position.
  function automatic logic [3:0] key_legend(input logic [3:0] pos);
    logic [3:0] leg;
    case (pos)
      4'd0:    leg = KEY_1;
      4'd1:    leg = KEY_2;
      4'd2:    leg = KEY_3;
      4'd3:    leg = KEY_A;
      4'd4:    leg = KEY_4;
      4'd5:    leg = KEY_5;
      4'd6:    leg = KEY_6;
      4'd7:    leg = KEY_B;
      4'd8:    leg = KEY_7;
      4'd9:    leg = KEY_8;
      4'd10:   leg = KEY_9;
      4'd11:   leg = KEY_C;
      4'd12:   leg = KEY_STAR;
      4'd13:   leg = KEY_0;
      4'd14:   leg = KEY_HASH;
      default: leg = KEY_D;
    endcase
    return leg;
  endfunction

endpackage

// File: rtl/module_row_sync.sv
// ---------------------------------------------------------------------------
// module_row_sync
//   Two-flop synchronizer for the 4 keypad row lines. Resets to 4'hF so the
//   scanner sees "no key" until real samples have propagated.
//   Ports:
//     clk    in  1  system clock
//     rst_n  in  1  asynchronous reset, active-low
//     row_i  in  4  raw rows, asynchronous to clk
//     row_o  out 4  synchronized rows
// ---------------------------------------------------------------------------
module module_row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] row_o
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ROWS_IDLE;
      sync_q <= ROWS_IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/module_keypad_scan.sv
// ---------------------------------------------------------------------------
// module_keypad_scan
//   Scans a 4x4 matrix keypad one column at a time, debounces the detected
//   key and presents its value (row*4+col) Gray-encoded on ag..dg, with a
//   one-clock key_valid strobe per accepted press.
//   Build option: define KEYPAD_REPEAT_EN to re-fire key_valid every
//   REPEAT_TICKS scan ticks while the accepted key stays pressed.
//   Ports:
//     clk        in   1  system clock
//     rst        in   1  asynchronous reset, active-low
//     row_i      in   4  keypad rows, active-low, asynchronous
//     col_o      out  4  column drive, one-cold
//     ag,bg,cg,dg out 1  Gray code of last accepted key, ag = MSB
//     key_valid  out  1  one-clock strobe, code valid in the same cycle
//     key_held   out  1  high while the accepted key remains pressed
// ---------------------------------------------------------------------------
module module_keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV         = 27_000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned REPEAT_TICKS     = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       ag,
  output logic       bg,
  output logic       cg,
  output logic       dg,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_SAMPLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  // A count sitting at DEB_LAST becomes DEBOUNCE_SAMPLES on the next
  // matching sample, which is the acceptance point.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_SAMPLES - 1);

  // -------------------------------------------------------------------------
  // Row synchronizer
  // -------------------------------------------------------------------------
  logic [3:0] rows_sync;

  module_row_sync u_row_sync (
    .clk   (clk),
    .rst_n (rst),
    .row_i (row_i),
    .row_o (rows_sync)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  state_t            state_q, state_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        cand_key_q, cand_key_d;
  logic [3:0]        cand_rows_q, cand_rows_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [3:0]        code_q, code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic tick;
  logic rows_idle;
  logic rep_fire;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign rows_idle = (rows_sync == ROWS_IDLE);

  // -------------------------------------------------------------------------
  // Auto-repeat
  // -------------------------------------------------------------------------
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // Counts held ticks; restarts on entry to HELD and on every all-high
  // sample, so a key that flickers open never fires an early repeat.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (state_q == PRESSED) begin
      rep_cnt_d = '0;
    end else if (state_q == HELD && tick) begin
      if (rows_idle) begin
        rep_cnt_d = '0;
      end else if (rep_cnt_q == REP_LAST) begin
        rep_cnt_d = '0;
        rep_fire  = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  logic [31:0] unused_repeat_ticks;
  assign unused_repeat_ticks = REPEAT_TICKS;
  assign rep_fire            = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Tick divider and scan FSM
  // -------------------------------------------------------------------------
  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
    state_d     = state_q;
    col_d       = col_q;
    cand_key_d  = cand_key_q;
    cand_rows_d = cand_rows_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    code_d      = code_q;
    key_held_d  = key_held_q;
    key_valid_d = rep_fire;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (rows_idle) begin
            col_d = {col_q[2:0], col_q[3]};
          end else begin
            // col_q stays frozen until the FSM is back in SCAN.
            cand_key_d  = key_value(lowest_low_row(rows_sync), col_index(col_q));
            cand_rows_d = rows_sync;
            deb_cnt_d   = DEB_W'(1);
            state_d     = DEBOUNCE;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (rows_sync == cand_rows_q) begin
            if (deb_cnt_q == DEB_LAST) begin
              state_d = PRESSED;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            // Bounce or release: drop the candidate, keep the column.
            deb_cnt_d = '0;
            state_d   = SCAN;
          end
        end
      end

      PRESSED: begin
        code_d      = to_gray(cand_key_q);
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        deb_cnt_d   = '0;
        rel_cnt_d   = '0;
        state_d     = HELD;
      end

      HELD: begin
        if (tick) begin
          if (rows_idle) begin
            if (rel_cnt_q == DEB_LAST) begin
              rel_cnt_d  = '0;
              key_held_d = 1'b0;
              state_d    = SCAN;
            end else begin
              rel_cnt_d = rel_cnt_q + DEB_W'(1);
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q  <= '0;
      state_q     <= SCAN;
      col_q       <= COL_RESET;
      cand_key_q  <= '0;
      cand_rows_q <= ROWS_IDLE;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      code_q      <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      col_q       <= col_d;
      cand_key_q  <= cand_key_d;
      cand_rows_q <= cand_rows_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      code_q      <= code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign col_o             = col_q;
  assign {ag, bg, cg, dg}  = code_q;
  assign key_valid         = key_valid_q;
  assign key_held          = key_held_q;

endmodule
